// File: rtl/pic_pkg.sv
// Shared FSM/read-select types and command bit positions for the PIC command sequencer.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ICW2 = 3'd1,
        W_ICW3 = 3'd2,
        W_ICW4 = 3'd3,
        READY  = 3'd4
    } pic_state_t;

    typedef enum logic {
        RD_IRR = 1'b0,
        RD_ISR = 1'b1
    } rd_sel_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int CMD_D4    = 4;
    localparam int OCW_D3    = 3;
    localparam int OCW3_RR   = 1;
    localparam int OCW3_RIS  = 0;

endpackage

// File: rtl/pic_bus_sync.sv
// Multi-flop synchroniser for the asynchronous CPU control pins plus a
// rising-edge detector on the synchronised write strobe.
module pic_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic CS,
    input  logic rd_enable,
    input  logic wr_enable,
    input  logic A1,
    output logic cs_s,
    output logic rd_s,
    output logic wr_s,
    output logic a1_s,
    output logic wr_rise
);
    logic [SYNC_STAGES-1:0] cs_ff;
    logic [SYNC_STAGES-1:0] rd_ff;
    logic [SYNC_STAGES-1:0] wr_ff;
    logic [SYNC_STAGES-1:0] a1_ff;
    logic                   wr_prev;

    // Active-low strobes reset to their idle level so no edge appears as reset lifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_ff   <= '1;
            rd_ff   <= '1;
            wr_ff   <= '1;
            a1_ff   <= '0;
            wr_prev <= 1'b1;
        end else begin
            cs_ff   <= {cs_ff[SYNC_STAGES-2:0], CS};
            rd_ff   <= {rd_ff[SYNC_STAGES-2:0], rd_enable};
            wr_ff   <= {wr_ff[SYNC_STAGES-2:0], wr_enable};
            a1_ff   <= {a1_ff[SYNC_STAGES-2:0], A1};
            wr_prev <= wr_ff[SYNC_STAGES-1];
        end
    end

    assign cs_s    = cs_ff[SYNC_STAGES-1];
    assign rd_s    = rd_ff[SYNC_STAGES-1];
    assign wr_s    = wr_ff[SYNC_STAGES-1];
    assign a1_s    = a1_ff[SYNC_STAGES-1];
    assign wr_rise = wr_s && !wr_prev;

endmodule

// File: rtl/pic_cmd_sequencer.sv
// 8259 command sequencer: ICW1..ICW4 init tracking, OCW registers, strobes and read-back.
// Optional build macro PIC_CMD_ERR_EN adds the sticky cmd_err output for ignored commits.
module pic_cmd_sequencer
    import pic_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IMR_RESET   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       rd_enable,
    input  logic       wr_enable,
    input  logic       A1,
    input  logic [7:0] bi_data_bus,
    input  logic [7:0] irr_in,
    input  logic [7:0] isr_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       write_ICW_1,
    output logic       write_ICW2_4,
    output logic       write_OCW1,
    output logic       write_OCW2,
    output logic       write_OCW3,
    output logic [7:0] icw1,
    output logic [7:0] icw2,
    output logic [7:0] icw3,
    output logic [7:0] icw4,
    output logic [7:0] imr,
    output logic [7:0] ocw2_data,
    output logic       initialized,
`ifdef PIC_CMD_ERR_EN
    output logic       cmd_err,
`endif
    output pic_state_t fsm_state
);
    logic       cs_s, rd_s, wr_s, a1_s, wr_rise;
    logic       cap_a1;
    logic [7:0] cap_data;
    logic       commit;
    pic_state_t state, state_d;
    rd_sel_t    rd_sel;
    logic       cmd_icw1, cmd_icw24, cmd_ocw1, cmd_ocw2, cmd_ocw3;

    pic_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .clk       (clk),
        .reset     (reset),
        .CS        (CS),
        .rd_enable (rd_enable),
        .wr_enable (wr_enable),
        .A1        (A1),
        .cs_s      (cs_s),
        .rd_s      (rd_s),
        .wr_s      (wr_s),
        .a1_s      (a1_s),
        .wr_rise   (wr_rise)
    );

    // A write counts only if CS is still low when the synced write strobe rises.
    assign commit = wr_rise && !cs_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_a1   <= 1'b0;
            cap_data <= 8'h00;
        end else if (!cs_s && !wr_s) begin
            cap_a1   <= a1_s;
            cap_data <= bi_data_bus;
        end
    end

    always_comb begin
        cmd_icw1  = 1'b0;
        cmd_icw24 = 1'b0;
        cmd_ocw1  = 1'b0;
        cmd_ocw2  = 1'b0;
        cmd_ocw3  = 1'b0;
        if (commit) begin
            if (!cap_a1 && cap_data[CMD_D4]) begin
                cmd_icw1 = 1'b1;
            end else begin
                case (state)
                    W_ICW2, W_ICW3, W_ICW4: cmd_icw24 = cap_a1;
                    READY: begin
                        if (cap_a1)                    cmd_ocw1 = 1'b1;
                        else if (!cap_data[OCW_D3])    cmd_ocw2 = 1'b1;
                        else                           cmd_ocw3 = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            icw1         <= 8'h00;
            icw2         <= 8'h00;
            icw3         <= 8'h00;
            icw4         <= 8'h00;
            imr          <= IMR_RESET;
            ocw2_data    <= 8'h00;
            rd_sel       <= RD_IRR;
            write_ICW_1  <= 1'b0;
            write_ICW2_4 <= 1'b0;
            write_OCW1   <= 1'b0;
            write_OCW2   <= 1'b0;
            write_OCW3   <= 1'b0;
        end else begin
            write_ICW_1  <= cmd_icw1;
            write_ICW2_4 <= cmd_icw24;
            write_OCW1   <= cmd_ocw1;
            write_OCW2   <= cmd_ocw2;
            write_OCW3   <= cmd_ocw3;
            if (cmd_icw1) begin
                icw1   <= cap_data;
                icw2   <= 8'h00;
                icw3   <= 8'h00;
                icw4   <= 8'h00;
                imr    <= IMR_RESET;
                rd_sel <= RD_IRR;
            end
            if (cmd_icw24) begin
                case (state)
                    W_ICW2:  icw2 <= cap_data;
                    W_ICW3:  icw3 <= cap_data;
                    W_ICW4:  icw4 <= cap_data;
                    default: ;
                endcase
            end
            if (cmd_ocw1) imr <= cap_data;
            if (cmd_ocw2) ocw2_data <= cap_data;
            if (cmd_ocw3 && cap_data[OCW3_RR])
                rd_sel <= cap_data[OCW3_RIS] ? RD_ISR : RD_IRR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Advance on the registered strobes so state trails the commit by one edge.
    always_comb begin
        state_d = state;
        if (write_ICW_1) begin
            state_d = W_ICW2;
        end else if (write_ICW2_4) begin
            case (state)
                W_ICW2: begin
                    if (!icw1[ICW1_SNGL])    state_d = W_ICW3;
                    else if (icw1[ICW1_IC4]) state_d = W_ICW4;
                    else                     state_d = READY;
                end
                W_ICW3:  state_d = icw1[ICW1_IC4] ? W_ICW4 : READY;
                W_ICW4:  state_d = READY;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= 8'h00;
            data_oe  <= 1'b0;
        end else begin
            data_oe  <= !cs_s && !rd_s;
            data_out <= a1_s ? imr : ((rd_sel == RD_ISR) ? isr_in : irr_in);
        end
    end

`ifdef PIC_CMD_ERR_EN
    logic cmd_bad;
    assign cmd_bad = commit && !(cmd_icw1 || cmd_icw24 || cmd_ocw1 || cmd_ocw2 || cmd_ocw3);

    always_ff @(posedge clk) begin
        if (reset || cmd_icw1) cmd_err <= 1'b0;
        else if (cmd_bad)      cmd_err <= 1'b1;
    end
`endif

    assign initialized = (state == READY);
    assign fsm_state   = state;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Directed bench for pic_cmd_sequencer: init sequences, OCW traffic, restart, gating and reset.
module tb_pic_cmd_sequencer;
    import pic_pkg::*;

    localparam int         SYNC  = 2;
    localparam logic [7:0] IMR_R = 8'h5C;

    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_ICW1 = 5'b10000;
    localparam logic [4:0] S_ICW24 = 5'b01000;
    localparam logic [4:0] S_OCW1 = 5'b00100;
    localparam logic [4:0] S_OCW2 = 5'b00010;
    localparam logic [4:0] S_OCW3 = 5'b00001;

    logic       clk = 1'b0;
    logic       reset, CS, rd_enable, wr_enable, A1;
    logic [7:0] bi_data_bus, irr_in, isr_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       write_ICW_1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3;
    logic [7:0] icw1, icw2, icw3, icw4, imr, ocw2_data;
    logic       initialized;
`ifdef PIC_CMD_ERR_EN
    logic       cmd_err;
`endif
    pic_state_t fsm_state;

    logic [4:0] exp_q[$];
    logic [7:0] rd_q[$];
    int n_vec = 0;
    int n_err = 0;

    pic_cmd_sequencer #(.SYNC_STAGES(SYNC), .IMR_RESET(IMR_R)) dut (
        .clk(clk), .reset(reset), .CS(CS), .rd_enable(rd_enable), .wr_enable(wr_enable),
        .A1(A1), .bi_data_bus(bi_data_bus), .irr_in(irr_in), .isr_in(isr_in),
        .data_out(data_out), .data_oe(data_oe),
        .write_ICW_1(write_ICW_1), .write_ICW2_4(write_ICW2_4), .write_OCW1(write_OCW1),
        .write_OCW2(write_OCW2), .write_OCW3(write_OCW3),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .imr(imr),
        .ocw2_data(ocw2_data), .initialized(initialized),
`ifdef PIC_CMD_ERR_EN
        .cmd_err(cmd_err),
`endif
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [4:0] strobes();
        return {write_ICW_1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one CPU write, then watch the strobes for a fixed window
    task automatic do_write(input logic a1, input logic [7:0] d, input logic [4:0] exp,
                            input bit cs_low = 1'b1, input bit cs_with_wr = 1'b0);
        logic [4:0] seen;
        int hits;
        int first;
        exp_q.push_back(exp);
        @(negedge clk);
        CS = !cs_low; A1 = a1; bi_data_bus = d; wr_enable = 1'b0;
        repeat (3) @(negedge clk);
        wr_enable = 1'b1;
        if (cs_with_wr) CS = 1'b1;
        seen = '0; hits = 0; first = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (strobes() != 5'b0) begin
                hits++;
                seen |= strobes();
                if (first == 0) first = i;
            end
        end
        CS = 1'b1;
        repeat (2) @(negedge clk);
        chk("strobe", seen, exp_q.pop_front());
        chk("strobe_cnt", hits, (exp != 5'b0) ? 1 : 0);
        if (exp != 5'b0) chk("wr_latency", first, SYNC + 1);
    endtask

    // driver: one CPU read, sampled exactly at the read latency
    task automatic do_read(input logic a1, input logic [7:0] exp);
        rd_q.push_back(exp);
        @(negedge clk);
        CS = 1'b0; A1 = a1; rd_enable = 1'b0;
        repeat (SYNC + 1) @(negedge clk);
        chk("data_oe", data_oe, 1);
        chk("data_out", data_out, rd_q.pop_front());
        rd_enable = 1'b1; CS = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        chk("data_oe_off", data_oe, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_strobes", strobes(), S_NONE);
        chk("rst_init", initialized, 0);
        chk("rst_state", fsm_state, IDLE);
        chk("rst_imr", imr, IMR_R);
        chk("rst_icw1", icw1, 8'h00);
        chk("rst_icw2", icw2, 8'h00);
        chk("rst_icw3", icw3, 8'h00);
        chk("rst_icw4", icw4, 8'h00);
        chk("rst_ocw2", ocw2_data, 8'h00);
    endtask

    initial begin
        reset = 1'b1; CS = 1'b1; rd_enable = 1'b1; wr_enable = 1'b1; A1 = 1'b0;
        bi_data_bus = 8'h00; irr_in = 8'h00; isr_in = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals();

        // illegal write in IDLE
        do_write(1'b1, 8'hAA, S_NONE);
        chk("idle_imr", imr, IMR_R);
        chk("idle_state", fsm_state, IDLE);
`ifdef PIC_CMD_ERR_EN
        chk("err_set_idle", cmd_err, 1);
`endif

        // single mode with ICW4
        do_write(1'b0, 8'h13, S_ICW1);
        chk("icw1", icw1, 8'h13);
        chk("st_w_icw2", fsm_state, W_ICW2);
`ifdef PIC_CMD_ERR_EN
        chk("err_clr_icw1", cmd_err, 0);
`endif
        do_write(1'b1, 8'h10, S_ICW24);
        chk("st_w_icw4", fsm_state, W_ICW4);
        chk("init_low", initialized, 0);
        do_write(1'b1, 8'h01, S_ICW24);
        chk("icw2", icw2, 8'h10);
        chk("icw4", icw4, 8'h01);
        chk("icw3_zero", icw3, 8'h00);
        chk("init_single", initialized, 1);

        // OCW traffic
        irr_in = 8'hA5; isr_in = 8'h5A;
        do_write(1'b1, 8'hF0, S_OCW1);
        chk("imr_ocw1", imr, 8'hF0);
        do_read(1'b1, 8'hF0);
        do_read(1'b0, 8'hA5);
        do_write(1'b0, 8'h0B, S_OCW3);
        do_read(1'b0, 8'h5A);
        do_write(1'b0, 8'h20, S_OCW2);
        chk("ocw2_data", ocw2_data, 8'h20);
        chk("imr_after_ocw2", imr, 8'hF0);

        // cascade without ICW4
        do_write(1'b0, 8'h10, S_ICW1);
        chk("imr_reinit", imr, IMR_R);
        chk("icw4_cleared", icw4, 8'h00);
        do_read(1'b0, 8'hA5);
        do_write(1'b1, 8'h20, S_ICW24);
        chk("st_w_icw3", fsm_state, W_ICW3);
        do_write(1'b1, 8'h04, S_ICW24);
        chk("icw3", icw3, 8'h04);
        chk("st_ready_casc", fsm_state, READY);
        chk("init_casc", initialized, 1);

        // restart from W_ICW4
        do_write(1'b0, 8'h13, S_ICW1);
        do_write(1'b1, 8'h10, S_ICW24);
        chk("st_w_icw4_b", fsm_state, W_ICW4);
        do_write(1'b0, 8'h11, S_ICW1);
        chk("restart_state", fsm_state, W_ICW2);
        chk("restart_imr", imr, IMR_R);
        chk("restart_icw1", icw1, 8'h11);

        // ignored and gated writes
        do_write(1'b0, 8'h08, S_NONE);
        chk("ignored_state", fsm_state, W_ICW2);
`ifdef PIC_CMD_ERR_EN
        chk("err_set_w2", cmd_err, 1);
`endif
        do_write(1'b1, 8'h33, S_NONE, 1'b0, 1'b0);
        do_write(1'b1, 8'h44, S_NONE, 1'b1, 1'b1);
        chk("gated_icw2", icw2, 8'h00);
        chk("gated_state", fsm_state, W_ICW2);

        // reset mid-write; write strobe rises as reset lifts
        irr_in = 8'h00;
        @(negedge clk);
        CS = 1'b0; A1 = 1'b1; bi_data_bus = 8'h77; wr_enable = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(S_NONE);
        repeat (3) @(negedge clk);
        reset = 1'b0; wr_enable = 1'b1;
        begin
            logic [4:0] seen;
            seen = '0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                seen |= strobes();
            end
            chk("post_reset_strobe", seen, exp_q.pop_front());
        end
        CS = 1'b1;
        A1 = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        chk_reset_vals();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
